// File: rtl/gate_bist_seq_pkg.sv
// Shared definitions for the gate BIST sequencer.
// Contents: gate function codes, FSM state encoding and the number of test vectors.
package gate_bist_seq_pkg;

    // Gate function codes presented on FUNC (6 and 7 are reserved)
    localparam logic [2:0] FN_OR   = 3'd0;
    localparam logic [2:0] FN_AND  = 3'd1;
    localparam logic [2:0] FN_NAND = 3'd2;
    localparam logic [2:0] FN_NOR  = 3'd3;
    localparam logic [2:0] FN_XOR  = 3'd4;
    localparam logic [2:0] FN_XNOR = 3'd5;

    // Every 2-input gate is exercised with all four (a,b) combinations
    localparam int NVEC = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_FIN   = 2'd2
    } state_t;

endpackage

// File: rtl/gate_bist_seq_truth_lut.sv
// Truth table of the supported 2-input gate functions.
// Returns the expected output for (a,b) and flags reserved function codes as invalid.
module gate_bist_seq_truth_lut
    import gate_bist_seq_pkg::*;
(
    input  logic [2:0] func,
    input  logic       a,
    input  logic       b,
    output logic       y,
    output logic       valid
);

    // Expected gate output; reserved codes yield y=0 with valid=0
    always_comb begin
        y     = 1'b0;
        valid = 1'b1;
        case (func)
            FN_OR:   y = a | b;
            FN_AND:  y = a & b;
            FN_NAND: y = ~(a & b);
            FN_NOR:  y = ~(a | b);
            FN_XOR:  y = a ^ b;
            FN_XNOR: y = ~(a ^ b);
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_bist_seq.sv
// Built-in self-test sequencer for a 2-input logic-gate package.
// Walks every gate through the vectors 00,01,10,11 (A=v[0], B=v[1]), holds each
// vector SETTLE cycles, compares Y with the truth table of the latched FUNC and
// accumulates sticky per-gate failure flags.
// Build option: GATE_BIST_SERIAL_EN tests one gate at a time (others held at
// A=B=0) so shorts between neighbouring pins become visible; otherwise all
// gates are driven and compared in parallel.
module gate_bist_seq
    import gate_bist_seq_pkg::*;
#(
    parameter int NGATES = 4,
    parameter int SETTLE = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [2:0]        FUNC,
    output logic [NGATES-1:0] A,
    output logic [NGATES-1:0] B,
    input  logic [NGATES-1:0] Y,
    output logic              BUSY,
    output logic              DONE,
    output logic              PASS,
    output logic [NGATES-1:0] FAIL_MASK
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);
    localparam logic [1:0]    V_LAST   = 2'(NVEC - 1);

    state_t            state_q, state_d;
    logic [2:0]        func_q, func_d;
    logic [1:0]        v_q, v_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NGATES-1:0] fail_q, fail_d;
    logic              pass_q, pass_d;

    logic [2:0]        lut_func;
    logic              exp_y;
    logic              lut_valid;
    logic              settle_last;
    logic              run_last;
    logic [NGATES-1:0] miss;

`ifdef GATE_BIST_SERIAL_EN
    localparam logic [2:0] G_LAST = 3'(NGATES - 1);
    logic [2:0]        gate_q, gate_d;
    logic [NGATES-1:0] sel;
`endif

    // In IDLE the LUT looks at the live FUNC so a reserved code is caught at START
    assign lut_func = (state_q == ST_IDLE) ? FUNC : func_q;

    gate_bist_seq_truth_lut u_lut (
        .func  (lut_func),
        .a     (v_q[0]),
        .b     (v_q[1]),
        .y     (exp_y),
        .valid (lut_valid)
    );

    assign settle_last = (cnt_q == CNT_LAST);

`ifdef GATE_BIST_SERIAL_EN
    // One-hot select of the gate currently under test
    always_comb begin
        sel = NGATES'(1) << gate_q;
    end

    assign run_last = settle_last && (v_q == V_LAST) && (gate_q == G_LAST);
`else
    assign run_last = settle_last && (v_q == V_LAST);
`endif

    // Per-gate mismatch against the expected value, limited to gates under test
    always_comb begin
        miss = Y ^ {NGATES{exp_y}};
`ifdef GATE_BIST_SERIAL_EN
        miss = miss & sel;
`endif
    end

    // State and datapath registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            func_q  <= FN_OR;
            v_q     <= '0;
            cnt_q   <= '0;
            fail_q  <= '0;
            pass_q  <= 1'b0;
`ifdef GATE_BIST_SERIAL_EN
            gate_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            func_q  <= func_d;
            v_q     <= v_d;
            cnt_q   <= cnt_d;
            fail_q  <= fail_d;
            pass_q  <= pass_d;
`ifdef GATE_BIST_SERIAL_EN
            gate_q  <= gate_d;
`endif
        end
    end

    // Next-state logic: reserved functions skip straight to FIN
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d = lut_valid ? ST_DRIVE : ST_FIN;
                end
            end
            ST_DRIVE: begin
                if (run_last) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Counters, function latch and sticky failure/pass bookkeeping
    always_comb begin
        func_d = func_q;
        v_d    = v_q;
        cnt_d  = cnt_q;
        fail_d = fail_q;
        pass_d = pass_q;
`ifdef GATE_BIST_SERIAL_EN
        gate_d = gate_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    func_d = FUNC;
                    v_d    = '0;
                    cnt_d  = '0;
                    pass_d = 1'b0;
                    fail_d = lut_valid ? '0 : '1;
`ifdef GATE_BIST_SERIAL_EN
                    gate_d = '0;
`endif
                end
            end
            ST_DRIVE: begin
                if (settle_last) begin
                    cnt_d  = '0;
                    fail_d = fail_q | miss;
                    v_d    = (v_q == V_LAST) ? 2'd0 : v_q + 2'd1;
`ifdef GATE_BIST_SERIAL_EN
                    if (v_q == V_LAST) begin
                        gate_d = (gate_q == G_LAST) ? 3'd0 : gate_q + 3'd1;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_FIN: begin
                pass_d = (fail_q == '0);
            end
            default: ;
        endcase
    end

    // Moore outputs: stimulus only while driving, DONE only in FIN
    always_comb begin
        A    = '0;
        B    = '0;
        BUSY = 1'b0;
        DONE = 1'b0;
        case (state_q)
            ST_DRIVE: begin
                BUSY = 1'b1;
`ifdef GATE_BIST_SERIAL_EN
                A = sel & {NGATES{v_q[0]}};
                B = sel & {NGATES{v_q[1]}};
`else
                A = {NGATES{v_q[0]}};
                B = {NGATES{v_q[1]}};
`endif
            end
            ST_FIN:  DONE = 1'b1;
            default: ;
        endcase
    end

    assign PASS      = pass_q;
    assign FAIL_MASK = fail_q;

endmodule
